peripheral_mult: RTL

Memory-mapped shift-and-add multiplier peripheral for the femtoriscv SoC. It occupies the chip-select slot for address window 0x0043xxxx (select line `cs[3]`), and its read data feeds the chip-select read mux as `chip3_dout`. Software writes two operands and starts the unit. It then polls status and reads a 2·WIDTH-bit product after a fixed latency.

---
 rtl/peripheral_mult_pkg.sv | 23 ++
 rtl/peripheral_mult_core.sv | 74 +++++++
 rtl/peripheral_mult.sv | 76 +++++++
 3 files changed

// File: rtl/peripheral_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier peripheral.
// Register offsets are word indices, which are taken from addr[4:2].
package peripheral_mult_pkg;

  localparam logic [2:0] MULT_A      = 3'd0;
  localparam logic [2:0] MULT_B      = 3'd1;
  localparam logic [2:0] MULT_CTRL   = 3'd2;
  localparam logic [2:0] MULT_STATUS = 3'd3;
  localparam logic [2:0] MULT_PP_LO  = 3'd4;
  localparam logic [2:0] MULT_PP_HI  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  // STATUS register layout: bit0 done, bit1 busy.
  function automatic logic [31:0] status_word(input logic busy, input logic done);
    return {30'd0, busy, done};
  endfunction

endpackage

// File: rtl/peripheral_mult_core.sv
// mult_core: shift-and-add multiplier FSM and datapath.
// Runs exactly WIDTH iterations after a start, independent of the operands.
module mult_core
  import peripheral_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   pp
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_e          state;
  mult_state_e          next_state;
  logic [2*WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [2*WIDTH-1:0]   pp_q;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 accept;

  assign last   = (cnt == CW'(WIDTH - 1));
  // A start is honoured only outside RUN; a start during RUN is dropped.
  assign accept = start && (state != ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_RUN;
      ST_RUN:  if (last)   next_state = ST_DONE;
      ST_DONE: if (accept) next_state = ST_RUN;
      default:             next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      pp_q <= '0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
      pp_q <= '0;
      cnt  <= '0;
    end else if (state == ST_RUN) begin
      if (b_sh[0]) pp_q <= pp_q + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
    end
  end

  assign pp = pp_q;

endmodule

// File: rtl/peripheral_mult.sv
// peripheral_mult: memory-mapped wrapper around mult_core with operand
// registers, address decode and a registered read-data port.
module peripheral_mult
  import peripheral_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out
);

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] pp;
  logic [63:0]        pp_ext;
  logic               busy;
  logic               done;
  logic               start;
  logic [2:0]         word;
  logic [31:0]        rd_data;
  logic               unused_bits;

  assign word        = addr[4:2];
  assign pp_ext      = 64'(pp);
  assign unused_bits = ^{addr[1:0], d_in};
  assign start       = cs && wr && (word == MULT_CTRL) && d_in[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (cs && wr) begin
      case (word)
        MULT_A:  a_reg <= d_in[WIDTH-1:0];
        MULT_B:  b_reg <= d_in[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Read mux sees pre-edge register values, so a same-cycle write is not visible.
  always_comb begin
    rd_data = '0;
    case (word)
      MULT_A:      rd_data = 32'(a_reg);
      MULT_B:      rd_data = 32'(b_reg);
      MULT_STATUS: rd_data = status_word(busy, done);
      MULT_PP_LO:  rd_data = pp_ext[31:0];
      MULT_PP_HI:  rd_data = pp_ext[63:32];
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          d_out <= '0;
    else if (cs && rd)  d_out <= rd_data;
  end

  mult_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a_reg),
    .b     (b_reg),
    .busy  (busy),
    .done  (done),
    .pp    (pp)
  );

endmodule
